// File: rtl/ddr3_cmd_pkg.sv
// Shared DDR3 command encodings ({cke,cs_n,ras_n,cas_n,we_n}) and the
// command issuer's state encoding.
package ddr3_cmd_pkg;

  localparam logic [4:0] CMD_LMR     = 5'b10000;
  localparam logic [4:0] CMD_REF     = 5'b10001;
  localparam logic [4:0] CMD_PRE     = 5'b10010;
  localparam logic [4:0] CMD_ACT     = 5'b10011;
  localparam logic [4:0] CMD_WR      = 5'b10100;
  localparam logic [4:0] CMD_RD      = 5'b10101;
  localparam logic [4:0] CMD_ZQ      = 5'b10110;
  localparam logic [4:0] CMD_NOP     = 5'b10111;
  localparam logic [4:0] CMD_CKE_LOW = 5'b01111;

  // Auto-precharge / ZQ-long flag bit on the address bus.
  localparam int ADDR_AP_BIT = 10;

  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_XPR, ST_LMR, ST_MOD_WAIT, ST_ZQCL, ST_ZQ_WAIT,
    ST_IDLE, ST_ACT, ST_RCD_WAIT, ST_RW, ST_AP_WAIT, ST_REF, ST_RFC_WAIT
  } state_e;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Free-running refresh interval timer: raises ref_pending on every wrap and
// flags an overrun when a wrap finds the previous refresh still unserved.
module ddr3_refresh_timer #(
  parameter int T_REFI = 3120
) (
  input  logic ck,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic ref_pending,
  output logic ref_overrun
);

  logic [15:0] cnt;
  logic        wrap;

  assign wrap = run && (cnt == 16'(T_REFI - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge ck) begin
    if (rst) begin
      cnt         <= '0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      ref_overrun <= wrap && ref_pending && !clear;
      if (run)
        cnt <= wrap ? '0 : cnt + 16'd1;
      // A wrap landing on the clear cycle re-arms the request.
      if (wrap)
        ref_pending <= 1'b1;
      else if (clear)
        ref_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr3_cmd_issuer.sv
// DDR3 command-bus initiator: power-up sequence, closed-page single-beat
// read/write service and periodic refresh, all pins registered.
module ddr3_cmd_issuer
  import ddr3_cmd_pkg::*;
#(
  parameter int          BA_BITS   = 3,
  parameter int          ADDR_BITS = 16,
  parameter int          COL_BITS  = 10,
  parameter int          T_INIT    = 200,
  parameter int          T_XPR     = 5,
  parameter int unsigned MR0_VALUE = 'h0520,
  parameter int          T_MOD     = 12,
  parameter int          T_ZQINIT  = 512,
  parameter int          T_RCD     = 4,
  parameter int          T_AP      = 8,
  parameter int          T_REFI    = 3120,
  parameter int          T_RFC     = 44
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BA_BITS-1:0]   req_bank,
  input  logic [ADDR_BITS-1:0] req_row,
  input  logic [COL_BITS-1:0]  req_col,
  output logic                 init_done,
  output logic                 ref_overrun,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr
);

  state_e               state, state_d;
  logic [15:0]          wait_cnt, cnt_d;
  logic [4:0]           cmd, cmd_d;
  logic [BA_BITS-1:0]   ba_d, lat_bank;
  logic [ADDR_BITS-1:0] addr_d, rw_addr;
  logic [COL_BITS-1:0]  lat_col;
  logic                 lat_write, accept, ref_clear, ref_pending;

  ddr3_refresh_timer #(.T_REFI(T_REFI)) u_refresh_timer (
    .ck          (ck),
    .rst         (rst),
    .run         (init_done),
    .clear       (ref_clear),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

  assign req_ready = (state == ST_IDLE) && !ref_pending;
  assign {cke, cs_n, ras_n, cas_n, we_n} = cmd;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = (wait_cnt == 16'd0) ? 16'd0 : wait_cnt - 16'd1;
    accept    = 1'b0;
    ref_clear = 1'b0;
    unique case (state)
      ST_INIT_WAIT: if (wait_cnt == 16'd0) begin
                      state_d = ST_INIT_XPR;
                      cnt_d   = 16'(T_XPR - 1);
                    end
      ST_INIT_XPR:  if (wait_cnt == 16'd0) state_d = ST_LMR;
      ST_LMR:       if (T_MOD > 1) begin
                      state_d = ST_MOD_WAIT;
                      cnt_d   = 16'(T_MOD - 2);
                    end else state_d = ST_ZQCL;
      ST_MOD_WAIT:  if (wait_cnt == 16'd0) state_d = ST_ZQCL;
      ST_ZQCL:      if (T_ZQINIT > 1) begin
                      state_d = ST_ZQ_WAIT;
                      cnt_d   = 16'(T_ZQINIT - 2);
                    end else state_d = ST_IDLE;
      ST_ZQ_WAIT:   if (wait_cnt == 16'd0) state_d = ST_IDLE;
      ST_IDLE:      if (ref_pending) begin
                      state_d   = ST_REF;
                      ref_clear = 1'b1;
                    end else if (req_valid) begin
                      state_d = ST_ACT;
                      accept  = 1'b1;
                    end
      ST_ACT:       if (T_RCD > 1) begin
                      state_d = ST_RCD_WAIT;
                      cnt_d   = 16'(T_RCD - 2);
                    end else state_d = ST_RW;
      ST_RCD_WAIT:  if (wait_cnt == 16'd0) state_d = ST_RW;
      ST_RW:        begin
                      state_d = ST_AP_WAIT;
                      cnt_d   = 16'(T_AP - 1);
                    end
      ST_AP_WAIT:   if (wait_cnt == 16'd0) state_d = ST_IDLE;
      ST_REF:       if (T_RFC > 1) begin
                      state_d = ST_RFC_WAIT;
                      cnt_d   = 16'(T_RFC - 2);
                    end else state_d = ST_IDLE;
      ST_RFC_WAIT:  if (wait_cnt == 16'd0) state_d = ST_IDLE;
      default:      state_d = ST_INIT_WAIT;
    endcase

    rw_addr                   = '0;
    rw_addr[COL_BITS-1:0]     = lat_col;
    rw_addr[ADDR_AP_BIT]      = 1'b1;

    // Pins are decoded from the state being entered, so they line up with it.
    cmd_d  = CMD_NOP;
    ba_d   = ba;
    addr_d = addr;
    case (state_d)
      ST_INIT_WAIT: cmd_d = CMD_CKE_LOW;
      ST_LMR:       begin
                      cmd_d  = CMD_LMR;
                      ba_d   = '0;
                      addr_d = ADDR_BITS'(MR0_VALUE);
                    end
      ST_ZQCL:      begin
                      cmd_d               = CMD_ZQ;
                      addr_d              = '0;
                      addr_d[ADDR_AP_BIT] = 1'b1;
                    end
      ST_ACT:       begin
                      cmd_d  = CMD_ACT;
                      ba_d   = req_bank;
                      addr_d = req_row;
                    end
      ST_RW:        begin
                      cmd_d  = lat_write ? CMD_WR : CMD_RD;
                      ba_d   = lat_bank;
                      addr_d = rw_addr;
                    end
      ST_REF:       cmd_d = CMD_REF;
      default:      ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state     <= ST_INIT_WAIT;
      wait_cnt  <= 16'(T_INIT - 1);
      cmd       <= CMD_CKE_LOW;
      ba        <= '0;
      addr      <= '0;
      init_done <= 1'b0;
      lat_write <= 1'b0;
      lat_bank  <= '0;
      lat_col   <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= cnt_d;
      cmd      <= cmd_d;
      ba       <= ba_d;
      addr     <= addr_d;
      if (state_d == ST_IDLE)
        init_done <= 1'b1;
      if (accept) begin
        lat_write <= req_write;
        lat_bank  <= req_bank;
        lat_col   <= req_col;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// Scoreboard bench for ddr3_cmd_issuer: expected commands are queued with
// their cycle stamp as stimulus is driven and matched as the bus shows them.
module tb_ddr3_cmd_issuer;
  import ddr3_cmd_pkg::*;

  localparam int T_INIT = 10, T_XPR = 2, T_MOD = 3, T_ZQINIT = 8;
  localparam int T_RCD = 4, T_AP = 8, T_AP_B = 60, T_REFI = 50, T_RFC = 6;
  localparam int LMR_CYC    = T_INIT + T_XPR;
  localparam int ZQ_CYC     = LMR_CYC + T_MOD;
  localparam int FIRST_IDLE = ZQ_CYC + T_ZQINIT;
  localparam int REF_SET    = FIRST_IDLE + T_REFI;

  typedef struct {
    int          cyc;
    logic [4:0]  code;
    logic        chk_ba;
    logic        chk_addr;
    logic [2:0]  ba;
    logic [15:0] addr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0, n_miss = 0;
  int   cyc = 0, cyc_b = 0, ovr_cnt_b = 0;

  logic        ck = 1'b0;
  logic        rst, req_valid, req_write, req_ready, init_done, ref_overrun;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  req_bank, ba;
  logic [15:0] req_row, addr;
  logic [9:0]  req_col;
  logic        rst_b, req_valid_b, req_write_b, req_ready_b, init_done_b, ref_overrun_b;
  logic        cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b;
  logic [2:0]  req_bank_b, ba_b;
  logic [15:0] req_row_b, addr_b;
  logic [9:0]  req_col_b;

  ddr3_cmd_issuer #(
    .T_INIT(T_INIT), .T_XPR(T_XPR), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
    .T_RCD(T_RCD), .T_AP(T_AP), .T_REFI(T_REFI), .T_RFC(T_RFC)
  ) dut (
    .ck(ck), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .init_done(init_done), .ref_overrun(ref_overrun), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr)
  );

  // Second instance with a very long auto-precharge window to force an overrun.
  ddr3_cmd_issuer #(
    .T_INIT(T_INIT), .T_XPR(T_XPR), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
    .T_RCD(T_RCD), .T_AP(T_AP_B), .T_REFI(T_REFI), .T_RFC(T_RFC)
  ) dut_b (
    .ck(ck), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_bank(req_bank_b), .req_row(req_row_b), .req_col(req_col_b),
    .init_done(init_done_b), .ref_overrun(ref_overrun_b), .cke(cke_b), .cs_n(cs_n_b),
    .ras_n(ras_n_b), .cas_n(cas_n_b), .we_n(we_n_b), .ba(ba_b), .addr(addr_b)
  );

  initial forever #5 ck = ~ck;

  always @(posedge ck) begin
    if (rst) cyc <= 0; else cyc <= cyc + 1;
    if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
  end

  function automatic logic [15:0] rw_addr(input logic [9:0] col);
    return 16'h0400 | {6'd0, col};
  endfunction

  task automatic push(input int d, input int c, input logic [4:0] code, input logic cb,
                      input logic ca, input logic [2:0] b, input logic [15:0] a);
    exp_t e;
    e.cyc = c; e.code = code; e.chk_ba = cb; e.chk_addr = ca; e.ba = b; e.addr = a;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic observe(input int d, input int c, input logic [4:0] code,
                         input logic [2:0] b, input logic [15:0] a);
    exp_t e;
    if (code[4] !== 1'b1 || code === CMD_NOP) return;
    n_vec++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_miss++;
      $display("FAIL cmd_unexpected dut%0d: got cyc %0d code %b ba %0h addr %h, expected no command",
               d, c, code, b, a);
      return;
    end
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    if (c !== e.cyc || code !== e.code || (e.chk_ba && b !== e.ba) || (e.chk_addr && a !== e.addr)) begin
      n_miss++;
      $display("FAIL cmd_dut%0d: got cyc %0d code %b ba %0h addr %h, expected cyc %0d code %b ba %0h addr %h",
               d, c, code, b, a, e.cyc, e.code, e.ba, e.addr);
    end
  endtask

  always @(negedge ck) begin
    observe(0, cyc, {cke, cs_n, ras_n, cas_n, we_n}, ba, addr);
    observe(1, cyc_b, {cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b}, ba_b, addr_b);
    if (ref_overrun_b === 1'b1) ovr_cnt_b++;
  end

  task automatic wait_to(input int d, input int t);
    int guard;
    guard = 0;
    while (((d == 0) ? cyc : cyc_b) < t) begin
      @(negedge ck);
      guard++;
      if (guard > 2000) begin
        n_vec++; n_miss++;
        $display("FAIL wait_timeout dut%0d: cycle %0d, required %0d", d, (d == 0) ? cyc : cyc_b, t);
        return;
      end
    end
  endtask

  task automatic wait_accept(input int d, output int acc);
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      if (((d == 0) ? req_ready : req_ready_b) === 1'b1) begin
        acc = (d == 0) ? cyc : cyc_b;
        break;
      end
      @(negedge ck);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] b, input logic [15:0] r, input logic [9:0] c);
    req_valid = 1'b1; req_write = w; req_bank = b; req_row = r; req_col = c;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_b = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_bank_b = '0; req_row_b = '0; req_col_b = '0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    n_vec++;
    if ({cke, cs_n, ras_n, cas_n, we_n, req_ready, init_done, ref_overrun} !== 8'b01111000) begin
      n_miss++;
      $display("FAIL reset_pins: got %b, expected 01111000",
               {cke, cs_n, ras_n, cas_n, we_n, req_ready, init_done, ref_overrun});
    end
    n_vec++;
    if ({ba, addr} !== 19'd0) begin
      n_miss++; $display("FAIL reset_bus: got ba %0h addr %h, expected 0", ba, addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_init;
    push(0, LMR_CYC, CMD_LMR, 1'b1, 1'b1, 3'd0, 16'h0520);
    push(0, ZQ_CYC, CMD_ZQ, 1'b0, 1'b1, 3'd0, 16'h0400);
    wait_to(0, T_INIT - 1);
    n_vec++;
    if (cke !== 1'b0) begin n_miss++; $display("FAIL init_cke_low: got %b, expected 0", cke); end
    wait_to(0, T_INIT);
    n_vec++;
    if (cke !== 1'b1) begin n_miss++; $display("FAIL init_cke_rise: got %b, expected 1", cke); end
    wait_to(0, FIRST_IDLE - 1);
    n_vec++;
    if ({init_done, req_ready} !== 2'b00) begin
      n_miss++; $display("FAIL init_early: got done/ready %b, expected 00", {init_done, req_ready});
    end
    wait_to(0, FIRST_IDLE);
    n_vec++;
    if ({init_done, req_ready} !== 2'b11) begin
      n_miss++; $display("FAIL init_done: got done/ready %b, expected 11", {init_done, req_ready});
    end
  endtask

  task automatic test_write;
    int n;
    n = 25;
    wait_to(0, n);
    drive(1'b1, 3'd2, 16'h1234, 10'h055);
    push(0, n + 1, CMD_ACT, 1'b1, 1'b1, 3'd2, 16'h1234);
    push(0, n + 1 + T_RCD, CMD_WR, 1'b1, 1'b1, 3'd2, 16'h0455);
    wait_to(0, n + 1);
    req_valid = 1'b0;
    wait_to(0, n + 1 + T_RCD + T_AP);
    n_vec++;
    if (req_ready !== 1'b0) begin n_miss++; $display("FAIL write_busy_ready: got %b, expected 0", req_ready); end
    wait_to(0, n + 2 + T_RCD + T_AP);
    n_vec++;
    if (req_ready !== 1'b1) begin n_miss++; $display("FAIL write_ready_back: got %b, expected 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    int n, acc;
    n = 40;
    wait_to(0, n);
    drive(1'b1, 3'd1, 16'h00AA, 10'h010);
    push(0, n + 1, CMD_ACT, 1'b1, 1'b1, 3'd1, 16'h00AA);
    push(0, n + 1 + T_RCD, CMD_WR, 1'b1, 1'b1, 3'd1, rw_addr(10'h010));
    wait_to(0, n + 1);
    req_valid = 1'b0;
    wait_to(0, n + 2);
    drive(1'b0, 3'd5, 16'hBEEF, 10'h3FF);
    push(0, n + 3 + T_RCD + T_AP, CMD_ACT, 1'b1, 1'b1, 3'd5, 16'hBEEF);
    push(0, n + 3 + 2 * T_RCD + T_AP, CMD_RD, 1'b1, 1'b1, 3'd5, 16'h07FF);
    wait_accept(0, acc);
    n_vec++;
    if (acc !== n + 2 + T_RCD + T_AP) begin
      n_miss++; $display("FAIL b2b_accept_cycle: got %0d, expected %0d", acc, n + 2 + T_RCD + T_AP);
    end
    @(negedge ck);
    req_valid = 1'b0;
  endtask

  task automatic test_refresh_priority;
    int acc;
    wait_to(0, REF_SET - 1);
    n_vec++;
    if (req_ready !== 1'b1) begin n_miss++; $display("FAIL prio_ready_before: got %b, expected 1", req_ready); end
    wait_to(0, REF_SET);
    n_vec++;
    if (req_ready !== 1'b0) begin n_miss++; $display("FAIL prio_ready_pending: got %b, expected 0", req_ready); end
    drive(1'b1, 3'd3, 16'h0F0F, 10'h2A0);
    push(0, REF_SET + 1, CMD_REF, 1'b0, 1'b0, 3'd0, 16'h0);
    push(0, REF_SET + 2 + T_RFC, CMD_ACT, 1'b1, 1'b1, 3'd3, 16'h0F0F);
    push(0, REF_SET + 2 + T_RFC + T_RCD, CMD_WR, 1'b1, 1'b1, 3'd3, 16'h06A0);
    wait_accept(0, acc);
    n_vec++;
    if (acc !== REF_SET + 1 + T_RFC) begin
      n_miss++; $display("FAIL prio_accept_cycle: got %0d, expected %0d", acc, REF_SET + 1 + T_RFC);
    end
    @(negedge ck);
    req_valid = 1'b0;
  endtask

  task automatic test_mid_reset;
    push(0, REF_SET + T_REFI + 1, CMD_REF, 1'b0, 1'b0, 3'd0, 16'h0);
    wait_to(0, 135);
    n_vec++;
    if (req_ready !== 1'b1) begin n_miss++; $display("FAIL midrst_ready: got %b, expected 1", req_ready); end
    drive(1'b0, 3'd6, 16'h4321, 10'h123);
    push(0, 136, CMD_ACT, 1'b1, 1'b1, 3'd6, 16'h4321);
    wait_to(0, 136);
    req_valid = 1'b0;
    wait_to(0, 137);
    rst = 1'b1;
    @(negedge ck);
    n_vec++;
    if ({cke, cs_n, ras_n, cas_n, we_n, init_done, req_ready} !== 7'b0111100) begin
      n_miss++;
      $display("FAIL midrst_pins: got %b, expected 0111100",
               {cke, cs_n, ras_n, cas_n, we_n, init_done, req_ready});
    end
    n_vec++;
    if ({ba, addr} !== 19'd0) begin
      n_miss++; $display("FAIL midrst_bus: got ba %0h addr %h, expected 0", ba, addr);
    end
    rst = 1'b0;
    push(0, LMR_CYC, CMD_LMR, 1'b1, 1'b1, 3'd0, 16'h0520);
    push(0, ZQ_CYC, CMD_ZQ, 1'b0, 1'b1, 3'd0, 16'h0400);
    wait_to(0, FIRST_IDLE - 1);
    n_vec++;
    if (init_done !== 1'b0) begin n_miss++; $display("FAIL midrst_done_early: got %b, expected 0", init_done); end
    wait_to(0, FIRST_IDLE);
    n_vec++;
    if (init_done !== 1'b1) begin n_miss++; $display("FAIL midrst_done: got %b, expected 1", init_done); end
    wait_to(0, FIRST_IDLE + 5);
    rst = 1'b1;
    n_vec++;
    if (q0.size() != 0) begin n_miss++; $display("FAIL midrst_queue: got %0d pending, expected 0", q0.size()); end
  endtask

  task automatic test_overrun;
    int n;
    n = 70;
    @(negedge ck);
    rst_b = 1'b0;
    push(1, LMR_CYC, CMD_LMR, 1'b1, 1'b1, 3'd0, 16'h0520);
    push(1, ZQ_CYC, CMD_ZQ, 1'b0, 1'b1, 3'd0, 16'h0400);
    wait_to(1, n);
    n_vec++;
    if (req_ready_b !== 1'b1) begin n_miss++; $display("FAIL ovr_ready: got %b, expected 1", req_ready_b); end
    req_valid_b = 1'b1; req_write_b = 1'b1; req_bank_b = 3'd7; req_row_b = 16'hFFFF; req_col_b = 10'h001;
    push(1, n + 1, CMD_ACT, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    push(1, n + 1 + T_RCD, CMD_WR, 1'b1, 1'b1, 3'd7, 16'h0401);
    push(1, n + 3 + T_RCD + T_AP_B, CMD_REF, 1'b0, 1'b0, 3'd0, 16'h0);
    wait_to(1, n + 1);
    req_valid_b = 1'b0;
    wait_to(1, REF_SET + T_REFI - 1);
    n_vec++;
    if (ref_overrun_b !== 1'b0) begin n_miss++; $display("FAIL ovr_before: got %b, expected 0", ref_overrun_b); end
    wait_to(1, REF_SET + T_REFI);
    n_vec++;
    if (ref_overrun_b !== 1'b1) begin n_miss++; $display("FAIL ovr_pulse: got %b, expected 1", ref_overrun_b); end
    wait_to(1, REF_SET + T_REFI + 1);
    n_vec++;
    if (ref_overrun_b !== 1'b0) begin n_miss++; $display("FAIL ovr_after: got %b, expected 0", ref_overrun_b); end
    wait_to(1, REF_SET + 2 * T_REFI - 3);
    n_vec++;
    if (ovr_cnt_b !== 1) begin n_miss++; $display("FAIL ovr_count: got %0d, expected 1", ovr_cnt_b); end
    n_vec++;
    if (q1.size() != 0) begin n_miss++; $display("FAIL ovr_queue: got %0d pending, expected 0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write();
    test_back_to_back();
    test_refresh_priority();
    test_mid_reset();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
